// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline.
// Turns load-use, taken-branch, memory-wait and syscall events into per-stage
// go/clear pairs for the PC and the IF_ID/ID_EX/EX_MEM/MEM_WB buffers. It also
// runs the syscall halt/resume FSM and keeps saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             syscall_wb,
    input  logic             resume,
    output logic             pc_go,
    output logic             ifid_go,
    output logic             ifid_clear,
    output logic             idex_go,
    output logic             idex_clear,
    output logic             exmem_go,
    output logic             exmem_clear,
    output logic             memwb_go,
    output logic             memwb_clear,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StHalt   = 2'd1;
    localparam logic [1:0] StResume = 2'd2;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             halted_q;
    logic             resume_q;
    logic             resume_edge;
    logic             inc_cycle, inc_stall, inc_flush;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    assign resume_edge = resume & ~resume_q;

    // Decode the active hazard into buffer controls, counter strobes and the next state.
    always_comb begin
        pc_go       = 1'b0;
        ifid_go     = 1'b0;
        ifid_clear  = 1'b0;
        idex_go     = 1'b0;
        idex_clear  = 1'b0;
        exmem_go    = 1'b0;
        exmem_clear = 1'b0;
        memwb_go    = 1'b0;
        memwb_clear = 1'b0;
        inc_cycle   = 1'b0;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        state_d     = state_q;

        case (state_q)
            StRun, StResume: begin
                inc_cycle = 1'b1;
                if (state_q == StRun && HALT_ON_SYSCALL && syscall_wb) begin
                    // Syscall wins over every other hazard; only cycle_cnt moves.
                    state_d = StHalt;
                end else if (mem_busy) begin
                    inc_stall = 1'b1;
                end else if (branch_taken) begin
                    // Squash the two wrong-path instructions; a load_use from
                    // that path is meaningless and is dropped.
                    pc_go      = 1'b1;
                    ifid_go    = 1'b1;
                    ifid_clear = 1'b1;
                    idex_go    = 1'b1;
                    idex_clear = 1'b1;
                    exmem_go   = 1'b1;
                    memwb_go   = 1'b1;
                    inc_flush  = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF_ID, inject a bubble into ID_EX.
                    idex_go    = 1'b1;
                    idex_clear = 1'b1;
                    exmem_go   = 1'b1;
                    memwb_go   = 1'b1;
                    inc_stall  = 1'b1;
                end else begin
                    pc_go    = 1'b1;
                    ifid_go  = 1'b1;
                    idex_go  = 1'b1;
                    exmem_go = 1'b1;
                    memwb_go = 1'b1;
                end
                // Once MEM_WB advances the held syscall has retired.
                if (state_q == StResume && memwb_go) begin
                    state_d = StRun;
                end
            end
            StHalt: begin
                if (resume_edge) begin
                    state_d = StResume;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Reset forces every buffer to load zeros so they come out of reset clean.
        if (rst) begin
            pc_go       = 1'b0;
            ifid_go     = 1'b0;
            ifid_clear  = 1'b1;
            idex_go     = 1'b0;
            idex_clear  = 1'b1;
            exmem_go    = 1'b0;
            exmem_clear = 1'b1;
            memwb_go    = 1'b0;
            memwb_clear = 1'b1;
        end
    end

    // FSM state, registered halt flag and resume edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalt);
            resume_q <= resume;
        end
    end

    // Non-halted cycle counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else if (inc_cycle && cycle_cnt_q != CntMax) begin
            cycle_cnt_q <= cycle_cnt_q + CntOne;
        end
    end

    // Load-use and memory-freeze cycle counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (inc_stall && stall_cnt_q != CntMax) begin
            stall_cnt_q <= stall_cnt_q + CntOne;
        end
    end

    // Branch flush counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (inc_flush && flush_cnt_q != CntMax) begin
            flush_cnt_q <= flush_cnt_q + CntOne;
        end
    end

    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a wide-counter and a 4-bit-counter instance share
// stimulus; a behavioural model predicts controls and counters every cycle.
module tb_pipe_hazard_ctrl;

    localparam int MRun = 0;
    localparam int MHalt = 1;
    localparam int MResume = 2;

    localparam logic [8:0] CtlReset  = 9'b001010101;
    localparam logic [8:0] CtlNormal = 9'b110101010;
    localparam logic [8:0] CtlFlush  = 9'b111111010;
    localparam logic [8:0] CtlStall  = 9'b000111010;
    localparam logic [8:0] CtlHold   = 9'b000000000;

    logic clk = 1'b0;
    logic rst;
    logic load_use = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
    logic syscall_wb = 1'b0, resume = 1'b0;

    logic        pc_go_a, ifid_go_a, ifid_clear_a, idex_go_a, idex_clear_a;
    logic        exmem_go_a, exmem_clear_a, memwb_go_a, memwb_clear_a, halted_a;
    logic [31:0] cycle_a, stall_a, flush_a;
    logic        pc_go_b, ifid_go_b, ifid_clear_b, idex_go_b, idex_clear_b;
    logic        exmem_go_b, exmem_clear_b, memwb_go_b, memwb_clear_b, halted_b;
    logic [3:0]  cycle_b, stall_b, flush_b;
    logic [8:0]  ctl_a, ctl_b;

    int vecs = 0;
    int errs = 0;

    // Model state
    int              m_mode = MRun;
    logic            m_resume_q = 1'b0;
    logic            m_halted = 1'b0;
    longint unsigned m_cycle = 0, m_stall = 0, m_flush = 0;

    pipe_hazard_ctrl #(.CNT_W(32), .HALT_ON_SYSCALL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .syscall_wb(syscall_wb), .resume(resume),
        .pc_go(pc_go_a), .ifid_go(ifid_go_a), .ifid_clear(ifid_clear_a),
        .idex_go(idex_go_a), .idex_clear(idex_clear_a), .exmem_go(exmem_go_a),
        .exmem_clear(exmem_clear_a), .memwb_go(memwb_go_a), .memwb_clear(memwb_clear_a),
        .halted(halted_a), .cycle_cnt(cycle_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .HALT_ON_SYSCALL(1'b1)) u_sat (
        .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .syscall_wb(syscall_wb), .resume(resume),
        .pc_go(pc_go_b), .ifid_go(ifid_go_b), .ifid_clear(ifid_clear_b),
        .idex_go(idex_go_b), .idex_clear(idex_clear_b), .exmem_go(exmem_go_b),
        .exmem_clear(exmem_clear_b), .memwb_go(memwb_go_b), .memwb_clear(memwb_clear_b),
        .halted(halted_b), .cycle_cnt(cycle_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    assign ctl_a = {pc_go_a, ifid_go_a, ifid_clear_a, idex_go_a, idex_clear_a,
                    exmem_go_a, exmem_clear_a, memwb_go_a, memwb_clear_a};
    assign ctl_b = {pc_go_b, ifid_go_b, ifid_clear_b, idex_go_b, idex_clear_b,
                    exmem_go_b, exmem_clear_b, memwb_go_b, memwb_clear_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // What the controls must be for this mode and these hazard inputs.
    function automatic logic [8:0] exp_ctl(input int mode);
        if (rst) return CtlReset;
        if (mode == MHalt) return CtlHold;
        if (mode == MRun && syscall_wb) return CtlHold;
        if (mem_busy) return CtlHold;
        if (branch_taken) return CtlFlush;
        if (load_use) return CtlStall;
        return CtlNormal;
    endfunction

    function automatic longint unsigned sat(input longint unsigned v, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: advance mode and counters on each clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode     <= MRun;
            m_resume_q <= 1'b0;
            m_halted   <= 1'b0;
            m_cycle    <= 0;
            m_stall    <= 0;
            m_flush    <= 0;
        end else begin
            int nxt;
            nxt = m_mode;
            m_resume_q <= resume;
            if (m_mode == MHalt) begin
                if (resume && !m_resume_q) nxt = MResume;
            end else begin
                m_cycle <= m_cycle + 1;
                if (m_mode == MRun && syscall_wb) begin
                    nxt = MHalt;
                end else if (mem_busy) begin
                    m_stall <= m_stall + 1;
                end else begin
                    if (branch_taken) m_flush <= m_flush + 1;
                    else if (load_use) m_stall <= m_stall + 1;
                    nxt = MRun;
                end
            end
            m_mode   <= nxt;
            m_halted <= (nxt == MHalt);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [8:0] e;
        e = exp_ctl(m_mode);
        check("ctl", ctl_a, e);
        check("ctl_w4", ctl_b, e);
        check("halted", halted_a, m_halted);
        check("halted_w4", halted_b, m_halted);
        check("cycle_cnt", cycle_a, sat(m_cycle, 32));
        check("stall_cnt", stall_a, sat(m_stall, 32));
        check("flush_cnt", flush_a, sat(m_flush, 32));
        check("cycle_cnt_w4", cycle_b, sat(m_cycle, 4));
        check("stall_cnt_w4", stall_b, sat(m_stall, 4));
        check("flush_cnt_w4", flush_b, sat(m_flush, 4));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("lit_rst_ctl", ctl_a, CtlReset);
        check("lit_rst_stall", stall_a, 0);
        rst = 1'b0;
        #1 check("lit_post_rst_ctl", ctl_a, CtlNormal);

        // Single load-use bubble
        step();
        load_use = 1'b1;
        #1 check("lit_load_use_ctl", ctl_a, CtlStall);
        step();
        load_use = 1'b0;
        #1 check("lit_load_use_stall", stall_a, 1);
        check("lit_after_stall_ctl", ctl_a, CtlNormal);

        // Branch overrides load-use
        branch_taken = 1'b1;
        load_use = 1'b1;
        #1 check("lit_br_lu_ctl", ctl_a, CtlFlush);
        step();
        branch_taken = 1'b0;
        load_use = 1'b0;
        #1 check("lit_br_lu_flush", flush_a, 1);
        check("lit_br_lu_stall", stall_a, 1);

        // Memory freeze beats branch
        mem_busy = 1'b1;
        branch_taken = 1'b1;
        repeat (3) begin
            #1 check("lit_freeze_ctl", ctl_a, CtlHold);
            step();
        end
        mem_busy = 1'b0;
        branch_taken = 1'b0;
        #1 check("lit_freeze_stall", stall_a, 4);
        check("lit_freeze_flush", flush_a, 1);

        // Syscall halt; resume already high must not release
        resume = 1'b1;
        step();
        syscall_wb = 1'b1;
        #1 check("lit_sys_ctl", ctl_a, CtlHold);
        step();
        #1 check("lit_halted", halted_a, 1);
        repeat (10) step();
        #1 check("lit_still_halted", halted_a, 1);
        check("lit_cycle_frozen", cycle_a, 8);
        resume = 1'b0;
        step();
        resume = 1'b1;
        #1 check("lit_halt_ctl", ctl_a, CtlHold);
        step();
        #1 check("lit_resume_ctl", ctl_a, CtlNormal);
        check("lit_resume_halted", halted_a, 0);
        step();
        syscall_wb = 1'b0;
        resume = 1'b0;
        #1 check("lit_run_ctl", ctl_a, CtlNormal);
        step();
        #1 check("lit_run_halted", halted_a, 0);

        // Reset mid-run, then saturate the 4-bit stall counter
        rst = 1'b1;
        #1 check("lit_midrst_stall", stall_a, 0);
        check("lit_midrst_ctl", ctl_a, CtlReset);
        step();
        rst = 1'b0;
        load_use = 1'b1;
        repeat (20) step();
        load_use = 1'b0;
        #1 check("lit_sat_w4", stall_b, 15);
        check("lit_sat_w32", stall_a, 20);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            step();
            if (rst) rst = ($urandom_range(1) == 0);
            else rst = ($urandom_range(249) == 0);
            load_use     = ($urandom_range(4) == 0);
            branch_taken = ($urandom_range(5) == 0);
            mem_busy     = ($urandom_range(6) == 0);
            syscall_wb   = ($urandom_range(24) == 0);
            if ($urandom_range(7) == 0) resume = ~resume;
        end
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
